// File: rtl/inst_fetch_req_ctrl.sv
// Instruction-fetch request controller: issues SRAM fetches, tracks/cancels in-flight responses, buffers for IF.
// Optional performance counters are added when ICTRL_PERF_CNT_EN is defined.
module inst_fetch_req_ctrl_chk #(
    parameter int CW              = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          data_ok,
    input logic [CW-1:0] out_cnt,
    input logic [CW-1:0] cancel_cnt
);
    a_no_spurious_data_ok: assert property (@(posedge clk) disable iff (!rst_n) data_ok |-> (out_cnt != {CW{1'b0}}));
    a_cancel_le_out:       assert property (@(posedge clk) disable iff (!rst_n) cancel_cnt <= out_cnt);
    a_out_le_max:          assert property (@(posedge clk) disable iff (!rst_n) {1'b0, out_cnt} <= (CW+1)'(MAX_OUTSTANDING));
endmodule

module inst_fetch_req_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int PC_W            = 32,
    parameter int INST_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_valid_i,
    input  logic [PC_W-1:0]   pre_pc_i,
    output logic              pre_ready_o,
    input  logic              excep_flush_i,
    input  logic              branch_flush_i,
    output logic              inst_sram_req_o,
    output logic [PC_W-1:0]   inst_sram_addr_o,
    input  logic              inst_sram_addr_ok_i,
    input  logic              inst_sram_data_ok_i,
    input  logic [INST_W-1:0] inst_sram_rdata_i,
    input  logic              if_allowin_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   inst_pc_o
`ifdef ICTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cancel_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);
    localparam int              CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int              IW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW:0]     MAX_W    = (CW+1)'(MAX_OUTSTANDING);
    localparam logic [IW-1:0]   LAST_IDX = IW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t            state_r, state_nxt_s;
    logic [PC_W-1:0]   addr_r, addr_nxt_s;
    logic              flush_seen_r, flush_seen_nxt_s;
    logic [CW-1:0]     out_cnt_r, cancel_cnt_r, fifo_cnt_r;
    logic [CW-1:0]     out_cnt_nxt_s, cancel_cnt_nxt_s, fifo_cnt_nxt_s;
    logic [PC_W-1:0]   pcq_r [MAX_OUTSTANDING];
    logic [IW-1:0]     pcq_wp_r, pcq_rp_r;
    logic [PC_W-1:0]   fifo_pc_r [MAX_OUTSTANDING];
    logic [INST_W-1:0] fifo_inst_r [MAX_OUTSTANDING];
    logic [IW-1:0]     fifo_wp_r, fifo_rp_r;
    logic [CW:0]       credit_sum_s;
    logic              flush_s, credit_ok_s, ready_s, addr_acc_s, data_ok_s;
    logic              drop_s, live_s, fifo_empty_s, push_s, pop_s;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (idx == LAST_IDX) begin
            next_idx = {IW{1'b0}};
        end else begin
            next_idx = idx + IW'(1'b1);
        end
    endfunction

    // The request being issued counts against the credit, so REQ and IDLE share one formula.
    assign flush_s      = excep_flush_i | branch_flush_i;
    assign credit_sum_s = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_r} + {{CW{1'b0}}, (state_r == REQ)};
    assign credit_ok_s  = credit_sum_s < MAX_W;
    assign addr_acc_s   = (state_r == REQ) & inst_sram_addr_ok_i;
    assign data_ok_s    = inst_sram_data_ok_i & (out_cnt_r != {CW{1'b0}});
    assign drop_s       = data_ok_s & (flush_s | (cancel_cnt_r != {CW{1'b0}}));
    assign live_s       = data_ok_s & ~drop_s;
    assign fifo_empty_s = (fifo_cnt_r == {CW{1'b0}});
    assign push_s       = live_s & ~(fifo_empty_s & if_allowin_i);
    assign pop_s        = ~flush_s & ~fifo_empty_s & if_allowin_i;

    assign pre_ready_o      = rst_n & ready_s;
    assign inst_sram_req_o  = (state_r == REQ);
    assign inst_sram_addr_o = addr_r;
    assign inst_valid_o     = rst_n & ~flush_s & (~fifo_empty_s | live_s);
    assign inst_o    = ~inst_valid_o ? {INST_W{1'b0}} : (fifo_empty_s ? inst_sram_rdata_i : fifo_inst_r[fifo_rp_r]);
    assign inst_pc_o = ~inst_valid_o ? {PC_W{1'b0}}   : (fifo_empty_s ? pcq_r[pcq_rp_r]   : fifo_pc_r[fifo_rp_r]);

    // Issue FSM: next state, request address and pre-IF ready
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        ready_s     = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = credit_ok_s & ~flush_s;
                if (pre_valid_i & ready_s) begin
                    state_nxt_s = REQ;
                    addr_nxt_s  = pre_pc_i;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                ready_s = addr_acc_s & credit_ok_s & ~flush_s;
                if (pre_valid_i & ready_s) begin
                    addr_nxt_s = pre_pc_i;
                end else if (addr_acc_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ready_s     = 1'b0;
            end
        endcase
    end

    // Counter updates; a flush re-derives cancel_cnt from the post-cycle outstanding count
    always_comb begin
        out_cnt_nxt_s    = out_cnt_r + CW'(addr_acc_s) - CW'(data_ok_s);
        cancel_cnt_nxt_s = cancel_cnt_r;
        fifo_cnt_nxt_s   = fifo_cnt_r;
        flush_seen_nxt_s = 1'b0;
        if (flush_s) begin
            cancel_cnt_nxt_s = out_cnt_nxt_s;
            fifo_cnt_nxt_s   = {CW{1'b0}};
        end else begin
            cancel_cnt_nxt_s = cancel_cnt_r + CW'(addr_acc_s & flush_seen_r) - CW'(drop_s);
            fifo_cnt_nxt_s   = fifo_cnt_r + CW'(push_s) - CW'(pop_s);
        end
        if ((state_r == REQ) & ~addr_acc_s) begin
            flush_seen_nxt_s = flush_seen_r | flush_s;
        end else begin
            flush_seen_nxt_s = 1'b0;
        end
    end

    // Control state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            addr_r       <= {PC_W{1'b0}};
            flush_seen_r <= 1'b0;
            out_cnt_r    <= {CW{1'b0}};
            cancel_cnt_r <= {CW{1'b0}};
            fifo_cnt_r   <= {CW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            addr_r       <= addr_nxt_s;
            flush_seen_r <= flush_seen_nxt_s;
            out_cnt_r    <= out_cnt_nxt_s;
            cancel_cnt_r <= cancel_cnt_nxt_s;
            fifo_cnt_r   <= fifo_cnt_nxt_s;
        end
    end

    // PC queue pairing accepted addresses with in-order responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) pcq_r[i] <= {PC_W{1'b0}};
            pcq_wp_r <= {IW{1'b0}};
            pcq_rp_r <= {IW{1'b0}};
        end else begin
            if (addr_acc_s) begin
                pcq_r[pcq_wp_r] <= addr_r;
                pcq_wp_r        <= next_idx(pcq_wp_r);
            end
            if (data_ok_s) pcq_rp_r <= next_idx(pcq_rp_r);
        end
    end

    // Response buffer holding instructions while IF stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_pc_r[i]   <= {PC_W{1'b0}};
                fifo_inst_r[i] <= {INST_W{1'b0}};
            end
            fifo_wp_r <= {IW{1'b0}};
            fifo_rp_r <= {IW{1'b0}};
        end else if (flush_s) begin
            fifo_wp_r <= {IW{1'b0}};
            fifo_rp_r <= {IW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc_r[fifo_wp_r]   <= pcq_r[pcq_rp_r];
                fifo_inst_r[fifo_wp_r] <= inst_sram_rdata_i;
                fifo_wp_r              <= next_idx(fifo_wp_r);
            end
            if (pop_s) fifo_rp_r <= next_idx(fifo_rp_r);
        end
    end

`ifdef ICTRL_PERF_CNT_EN
    logic [31:0] perf_cancel_r, perf_stall_r;

    // Event counters for dropped responses and pre-IF stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cancel_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else begin
            perf_cancel_r <= perf_cancel_r + {31'd0, drop_s};
            perf_stall_r  <= perf_stall_r + {31'd0, pre_valid_i & ~pre_ready_o};
        end
    end

    assign perf_cancel_cnt_o = perf_cancel_r;
    assign perf_stall_cnt_o  = perf_stall_r;
`endif

    inst_fetch_req_ctrl_chk #(.CW(CW), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ok    (inst_sram_data_ok_i),
        .out_cnt    (out_cnt_r),
        .cancel_cnt (cancel_cnt_r)
    );
endmodule

// File: tb/tb_inst_fetch_req_ctrl.sv
// Self-checking bench for inst_fetch_req_ctrl: scenario tasks plus an in-order delivery scoreboard.
module tb_inst_fetch_req_ctrl;
    logic        clk, rst_n;
    logic        pre_valid_i, pre_ready_o, excep_flush_i, branch_flush_i;
    logic [31:0] pre_pc_i, inst_sram_addr_o, inst_sram_rdata_i, inst_o, inst_pc_o;
    logic        inst_sram_req_o, inst_sram_addr_ok_i, inst_sram_data_ok_i, if_allowin_i, inst_valid_o;
`ifdef ICTRL_PERF_CNT_EN
    logic [31:0] perf_cancel_cnt_o, perf_stall_cnt_o;
`endif

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] sram_q[$];

    inst_fetch_req_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pre_valid_i(pre_valid_i), .pre_pc_i(pre_pc_i), .pre_ready_o(pre_ready_o),
        .excep_flush_i(excep_flush_i), .branch_flush_i(branch_flush_i),
        .inst_sram_req_o(inst_sram_req_o), .inst_sram_addr_o(inst_sram_addr_o),
        .inst_sram_addr_ok_i(inst_sram_addr_ok_i), .inst_sram_data_ok_i(inst_sram_data_ok_i),
        .inst_sram_rdata_i(inst_sram_rdata_i), .if_allowin_i(if_allowin_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
`ifdef ICTRL_PERF_CNT_EN
        , .perf_cancel_cnt_o(perf_cancel_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] pc);
        if (pc == 32'h1c000000) mem = 32'h02800c00;
        else mem = {pc[15:0], pc[31:16]} ^ 32'h00a5_0000;
    endfunction

    // Scoreboard: in-order delivery check, flush cancellation, SRAM accepted-address tracking
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            exp_q.delete();
            sram_q.delete();
        end else begin
            if (inst_valid_o && if_allowin_i) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got pc %h inst %h, required no delivery", inst_pc_o, inst_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({inst_pc_o, inst_o} !== e)
                        $display("FAIL sb_deliver: got pc %h inst %h, required pc %h inst %h", inst_pc_o, inst_o, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
            if (excep_flush_i || branch_flush_i) exp_q.delete();
            if (pre_valid_i && pre_ready_o) exp_q.push_back({pre_pc_i, mem(pre_pc_i)});
            if (inst_sram_data_ok_i && sram_q.size() > 0) void'(sram_q.pop_front());
            if (inst_sram_req_o && inst_sram_addr_ok_i) sram_q.push_back(inst_sram_addr_o);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        pre_valid_i = 1'b0; inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b0;
        excep_flush_i = 1'b0; branch_flush_i = 1'b0;
    endtask

    task automatic drive_resp();
        chk_cnt++;
        if (sram_q.size() == 0) begin
            $display("FAIL resp_pending: got 0 accepted requests, required at least 1");
        end else begin
            pass_cnt++;
            inst_sram_data_ok_i = 1'b1;
            inst_sram_rdata_i   = mem(sram_q[0]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if ({inst_sram_req_o, inst_sram_addr_o} !== 33'd0) $display("FAIL rst_req_addr: got %b/%h required 0/0", inst_sram_req_o, inst_sram_addr_o); else pass_cnt++;
        chk_cnt++; if (inst_valid_o !== 1'b0) $display("FAIL rst_valid: got %b required 0", inst_valid_o); else pass_cnt++;
        chk_cnt++; if (pre_ready_o !== 1'b0) $display("FAIL rst_ready: got %b required 0", pre_ready_o); else pass_cnt++;
        chk_cnt++; if ({inst_o, inst_pc_o} !== 64'd0) $display("FAIL rst_inst: got %h/%h required 0/0", inst_o, inst_pc_o); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", pre_ready_o); else pass_cnt++;
    endtask

    task automatic test_single_fetch();
        cyc(); pre_valid_i = 1'b1; pre_pc_i = 32'h1c000000; @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b1) $display("FAIL t1_ready: got %b required 1", pre_ready_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if ({inst_sram_req_o, inst_sram_addr_o} !== {1'b1, 32'h1c000000}) $display("FAIL t1_req_c1: got %b/%h required 1/1c000000", inst_sram_req_o, inst_sram_addr_o); else pass_cnt++;
        cyc(); inst_sram_addr_ok_i = 1'b1; @(negedge clk);
        chk_cnt++; if (inst_sram_req_o !== 1'b1) $display("FAIL t1_req_c2: got %b required 1", inst_sram_req_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if (inst_sram_req_o !== 1'b0) $display("FAIL t1_req_c3: got %b required 0", inst_sram_req_o); else pass_cnt++;
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h02800c00, 32'h1c000000}) $display("FAIL t1_deliver: got %b/%h/%h required 1/02800c00/1c000000", inst_valid_o, inst_o, inst_pc_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if (inst_valid_o !== 1'b0) $display("FAIL t1_valid_after: got %b required 0", inst_valid_o); else pass_cnt++;
        cyc();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL t1_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_credit_limit();
        logic [31:0] pc;
        int          hs, iss;
        pc = 32'h1c001000; hs = 0; iss = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); pre_valid_i = 1'b1; pre_pc_i = pc; inst_sram_addr_ok_i = 1'b1;
            @(negedge clk);
            if (pre_valid_i && pre_ready_o) begin hs++; pc = pc + 32'd4; end
            if (inst_sram_req_o && inst_sram_addr_ok_i) iss++;
        end
        chk_cnt++; if (hs != 2) $display("FAIL t2_handshakes: got %0d required 2", hs); else pass_cnt++;
        chk_cnt++; if (iss != 2) $display("FAIL t2_issued: got %0d required 2", iss); else pass_cnt++;
        chk_cnt++; if (pre_ready_o !== 1'b0) $display("FAIL t2_ready_blocked: got %b required 0", pre_ready_o); else pass_cnt++;
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b0) $display("FAIL t2_ready_resp_cycle: got %b required 0", pre_ready_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b1) $display("FAIL t2_ready_freed: got %b required 1", pre_ready_o); else pass_cnt++;
        cyc(); drive_resp(); @(negedge clk);
        cyc();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL t2_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic issue_two(input logic [31:0] pc0);
        cyc(); pre_valid_i = 1'b1; pre_pc_i = pc0; @(negedge clk);
        cyc(); pre_valid_i = 1'b1; pre_pc_i = pc0 + 32'd4; inst_sram_addr_ok_i = 1'b1; @(negedge clk);
        cyc(); inst_sram_addr_ok_i = 1'b1; @(negedge clk);
    endtask

    task automatic test_flush_outstanding();
        issue_two(32'h1c004000);
        cyc(); branch_flush_i = 1'b1; @(negedge clk);
        chk_cnt++; if ({pre_ready_o, inst_valid_o} !== 2'b00) $display("FAIL t3_flush_cycle: got ready %b valid %b required 0 0", pre_ready_o, inst_valid_o); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            cyc(); drive_resp(); @(negedge clk);
            chk_cnt++; if (inst_valid_o !== 1'b0) $display("FAIL t3_drop%0d: got valid %b required 0", i, inst_valid_o); else pass_cnt++;
        end
        cyc(); pre_valid_i = 1'b1; pre_pc_i = 32'h1c000100; @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b1) $display("FAIL t3_ready_new: got %b required 1", pre_ready_o); else pass_cnt++;
        cyc(); inst_sram_addr_ok_i = 1'b1; @(negedge clk);
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h1c000100}) $display("FAIL t3_new_deliver: got %b/%h required 1/1c000100", inst_valid_o, inst_pc_o); else pass_cnt++;
        cyc();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL t3_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_flush_in_req();
        cyc(); pre_valid_i = 1'b1; pre_pc_i = 32'h1c002000; @(negedge clk);
        cyc(); excep_flush_i = 1'b1; @(negedge clk);
        chk_cnt++; if ({inst_sram_req_o, inst_sram_addr_o} !== {1'b1, 32'h1c002000}) $display("FAIL t4_req_flush: got %b/%h required 1/1c002000", inst_sram_req_o, inst_sram_addr_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if ({inst_sram_req_o, inst_sram_addr_o} !== {1'b1, 32'h1c002000}) $display("FAIL t4_req_hold: got %b/%h required 1/1c002000", inst_sram_req_o, inst_sram_addr_o); else pass_cnt++;
        cyc(); inst_sram_addr_ok_i = 1'b1; @(negedge clk);
        cyc(); pre_valid_i = 1'b1; pre_pc_i = 32'h1c002040; @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b1) $display("FAIL t4_ready_next: got %b required 1", pre_ready_o); else pass_cnt++;
        cyc(); inst_sram_addr_ok_i = 1'b1; @(negedge clk);
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if (inst_valid_o !== 1'b0) $display("FAIL t4_drop: got valid %b required 0", inst_valid_o); else pass_cnt++;
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h1c002040}) $display("FAIL t4_deliver: got %b/%h required 1/1c002040", inst_valid_o, inst_pc_o); else pass_cnt++;
        cyc();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL t4_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_if_stall();
        if_allowin_i = 1'b0;
        issue_two(32'h1c003000);
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h1c003000}) $display("FAIL t5_first_resp: got %b/%h required 1/1c003000", inst_valid_o, inst_pc_o); else pass_cnt++;
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h1c003000}) $display("FAIL t5_head_hold: got %b/%h required 1/1c003000", inst_valid_o, inst_pc_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b0) $display("FAIL t5_fifo_full: got ready %b required 0", pre_ready_o); else pass_cnt++;
        cyc(); if_allowin_i = 1'b1; @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h1c003000}) $display("FAIL t5_drain0: got %b/%h required 1/1c003000", inst_valid_o, inst_pc_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h1c003004}) $display("FAIL t5_drain1: got %b/%h required 1/1c003004", inst_valid_o, inst_pc_o); else pass_cnt++;
        cyc(); @(negedge clk);
        chk_cnt++; if (inst_valid_o !== 1'b0) $display("FAIL t5_drained: got valid %b required 0", inst_valid_o); else pass_cnt++;
        cyc();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL t5_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        if_allowin_i = 1'b0;
        issue_two(32'h1c005000);
        cyc(); drive_resp(); @(negedge clk);
        cyc(); #2;
        chk_cnt++; if (inst_valid_o !== 1'b1) $display("FAIL t6_pre_reset_valid: got %b required 1", inst_valid_o); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({inst_sram_req_o, inst_sram_addr_o} !== 33'd0) $display("FAIL t6_req_addr: got %b/%h required 0/0", inst_sram_req_o, inst_sram_addr_o); else pass_cnt++;
        chk_cnt++; if ({inst_valid_o, pre_ready_o} !== 2'b00) $display("FAIL t6_valid_ready: got %b/%b required 0/0", inst_valid_o, pre_ready_o); else pass_cnt++;
        chk_cnt++; if ({inst_o, inst_pc_o} !== 64'd0) $display("FAIL t6_inst: got %h/%h required 0/0", inst_o, inst_pc_o); else pass_cnt++;
        if_allowin_i = 1'b1;
        repeat (2) @(posedge clk);
        cyc(); rst_n = 1'b1;
        cyc(); pre_valid_i = 1'b1; pre_pc_i = 32'h1c000200; @(negedge clk);
        chk_cnt++; if (pre_ready_o !== 1'b1) $display("FAIL t6_ready_after: got %b required 1", pre_ready_o); else pass_cnt++;
        cyc(); inst_sram_addr_ok_i = 1'b1; @(negedge clk);
        cyc(); drive_resp(); @(negedge clk);
        chk_cnt++; if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 32'h1c000200, mem(32'h1c000200)}) $display("FAIL t6_fresh_fetch: got %b/%h/%h required 1/1c000200/%h", inst_valid_o, inst_pc_o, inst_o, mem(32'h1c000200)); else pass_cnt++;
        cyc();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL t6_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pre_valid_i = 1'b0; pre_pc_i = 32'd0; excep_flush_i = 1'b0; branch_flush_i = 1'b0;
        inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b0; inst_sram_rdata_i = 32'd0; if_allowin_i = 1'b1;
        test_reset();
        test_single_fetch();
        test_credit_limit();
        test_flush_outstanding();
        test_flush_in_req();
        test_if_stall();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
